// File: rtl/axis_uart_rx_packer_if.sv
// AXI-Stream bundle carrying packed UART words out of axis_uart_rx_packer.
// Port names keep the M_AXIS_* spelling used by the surrounding design.
interface axis_uart_rx_packer_if #(
    parameter int N_BYTES = 4
);
    logic [N_BYTES*8-1:0] M_AXIS_TDATA;
    logic [N_BYTES-1:0]   M_AXIS_TKEEP;
    logic                 M_AXIS_TLAST;
    logic                 M_AXIS_TVALID;
    logic                 M_AXIS_TREADY;

    // A beat moves on every cycle with TVALID & TREADY; while TVALID is high and TREADY low,
    // TVALID stays high and TDATA/TKEEP/TLAST hold their values.
    modport master (
        output M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TVALID,
        input  M_AXIS_TREADY
    );
    modport slave (
        input  M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TVALID,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/axis_uart_rx_packer.sv
// UART receiver packing bytes into AXIS words with idle flush, error pulses and an FWFT queue.
// Define UART_RX_PARITY_EN to receive 8-data + parity frames; otherwise frames are 8N1.
module axis_uart_rx_packer #(
    parameter int FREQ_HZ           = 100000000,
    parameter int UART_SPEED        = 115200,
    parameter int N_BYTES           = 4,
    parameter int QUEUE_DEPTH       = 16,
    parameter int IDLE_TIMEOUT_BITS = 16,
    parameter int PARITY_ODD        = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         UART_RX,
    axis_uart_rx_packer_if.master        m_axis,
    output logic                         FRAME_ERR,
    output logic                         PARITY_ERR,
    output logic                         OVERFLOW,
    output logic [2:0]                   dbg_state
);
    localparam int BIT_PERIOD = FREQ_HZ / UART_SPEED;
    localparam int HALF       = BIT_PERIOD / 2;
    localparam int CNT_W      = $clog2(BIT_PERIOD + 1);
    localparam int IDLE_LIMIT = IDLE_TIMEOUT_BITS * BIT_PERIOD;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
    localparam int BCW        = $clog2(N_BYTES + 1);
    localparam int DW         = N_BYTES * 8;
    localparam int EW         = DW + N_BYTES + 1;
    localparam int AW         = $clog2(QUEUE_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_bad_q, par_bad_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DW-1:0]    word_q, word_d, lane_word;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;
    logic             overflow_q, overflow_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]    mem_q [QUEUE_DEPTH];
    logic [EW-1:0]    push_entry, q_head;
    logic [N_BYTES-1:0] keep;
    logic             tc, push, push_ok, pop, q_empty, q_full;

    assign tc      = (cnt_q == '0);
    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign pop     = !q_empty && m_axis.M_AXIS_TREADY;

    // State register: every flop of the block, including the 2-FF synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            idle_q       <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            rx_meta_q    <= UART_RX;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            idle_q       <= idle_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end

    // Next state. IDLE is only re-entered with rx_s high, so a low level there is a falling edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            S_IDLE: if (!rx_s_q) begin
                state_d = S_START;
                cnt_d   = CNT_W'(HALF);
            end
            S_START: if (!tc) cnt_d = cnt_q - 1'b1;
                     else if (!rx_s_q) begin
                         state_d   = S_DATA;
                         cnt_d     = CNT_W'(BIT_PERIOD - 1);
                         bit_idx_d = '0;
                     end else state_d = S_IDLE;
            S_DATA: if (!tc) cnt_d = cnt_q - 1'b1;
                    else begin
                        cnt_d     = CNT_W'(BIT_PERIOD - 1);
                        bit_idx_d = bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
                        if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
                    end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (!tc) cnt_d = cnt_q - 1'b1;
                      else begin
                          state_d = S_STOP;
                          cnt_d   = CNT_W'(BIT_PERIOD - 1);
                      end
`endif
            S_STOP: if (!tc) cnt_d = cnt_q - 1'b1;
                    else state_d = rx_s_q ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath: sampling, packing, idle flush, queue pointers and error pulses.
    always_comb begin
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        idle_d       = '0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overflow_d   = 1'b0;
        push         = 1'b0;
        push_ok      = 1'b0;
        push_entry   = '0;
        lane_word    = word_q;
        keep         = '0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        for (int i = 0; i < N_BYTES; i++) begin
            keep[i] = (BCW'(i) < byte_cnt_q);
            if (BCW'(i) == byte_cnt_q) lane_word[i*8 +: 8] = shift_q;
        end

        if (state_q == S_DATA && tc) shift_d = {rx_s_q, shift_q[7:1]};
`ifdef UART_RX_PARITY_EN
        if (state_q == S_PARITY && tc) par_bad_d = (^shift_q) ^ rx_s_q ^ PARITY_ODD[0];
`else
        par_bad_d = par_bad_q & PARITY_ODD[0];  // holds its reset value of 0 in 8N1 builds
`endif

        // A bad stop bit masks a parity error on the same frame.
        if (state_q == S_STOP && tc) begin
            if (!rx_s_q) frame_err_d = 1'b1;
            else if (par_bad_q) parity_err_d = 1'b1;
            else if (byte_cnt_q == BCW'(N_BYTES - 1)) begin
                push       = 1'b1;
                push_entry = {1'b0, {N_BYTES{1'b1}}, lane_word};
                byte_cnt_d = '0;
                word_d     = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                word_d     = lane_word;
            end
        end

        if (state_q == S_IDLE && byte_cnt_q != '0 && rx_s_q) begin
            if (idle_q == IDLE_W'(IDLE_LIMIT - 1)) begin
                push       = 1'b1;
                push_entry = {1'b1, keep, word_q};
                byte_cnt_d = '0;
                word_d     = '0;
            end else idle_d = idle_q + 1'b1;
        end

        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) begin
            if (q_full && !pop) overflow_d = 1'b1;
            else begin
                push_ok  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    assign q_head               = mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis.M_AXIS_TVALID = !q_empty;
    assign m_axis.M_AXIS_TDATA  = q_empty ? '0 : q_head[DW-1:0];
    assign m_axis.M_AXIS_TKEEP  = q_empty ? '0 : q_head[DW +: N_BYTES];
    assign m_axis.M_AXIS_TLAST  = q_empty ? 1'b0 : q_head[EW-1];
    assign FRAME_ERR            = frame_err_q;
    assign PARITY_ERR           = parity_err_q;
    assign OVERFLOW             = overflow_q;
    assign dbg_state            = state_q;
endmodule

// File: tb/tb_axis_uart_rx_packer.sv
// Bench for axis_uart_rx_packer: directed scenarios plus random bytes against a byte-level model.
// Build with UART_RX_PARITY_EN to also exercise parity frames.
module tb_axis_uart_rx_packer;
    localparam int FREQ_HZ           = 1600000;
    localparam int UART_SPEED        = 100000;
    localparam int N_BYTES           = 4;
    localparam int QUEUE_DEPTH       = 2;
    localparam int IDLE_TIMEOUT_BITS = 16;
    localparam int PARITY_ODD        = 0;
    localparam int BP                = FREQ_HZ / UART_SPEED;
    localparam int W                 = N_BYTES * 8 + N_BYTES + 1;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PARITY = 1'b1;
`else
    localparam bit HAS_PARITY = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       frame_err, parity_err, overflow;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    axis_uart_rx_packer_if #(.N_BYTES(N_BYTES)) m_axis ();

    axis_uart_rx_packer #(
        .FREQ_HZ(FREQ_HZ), .UART_SPEED(UART_SPEED), .N_BYTES(N_BYTES),
        .QUEUE_DEPTH(QUEUE_DEPTH), .IDLE_TIMEOUT_BITS(IDLE_TIMEOUT_BITS), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk), .reset(reset), .UART_RX(uart_rx), .m_axis(m_axis),
        .FRAME_ERR(frame_err), .PARITY_ERR(parity_err), .OVERFLOW(overflow), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [7:0]   pend_q[$];
    int total = 0, bad = 0;
    int exp_frame = 0, exp_parity = 0, exp_ovf = 0;
    int got_frame = 0, got_parity = 0, got_ovf = 0;
    bit hold_ready = 1'b0;
    logic [W-1:0] cur_word, prev_word, want_word;
    bit prev_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_push(input logic [W-1:0] w);
        // Capacity only matters while the consumer is held off; otherwise the queue drains.
        if (hold_ready && exp_q.size() >= QUEUE_DEPTH) exp_ovf++;
        else exp_q.push_back(w);
    endfunction

    function automatic logic [W-1:0] model_pack(input bit last);
        logic [N_BYTES*8-1:0] d = '0;
        logic [N_BYTES-1:0]   k = '0;
        foreach (pend_q[i]) begin
            d[i*8 +: 8] = pend_q[i];
            k[i] = 1'b1;
        end
        pend_q.delete();
        return {last, k, d};
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        if (!stop_ok) exp_frame++;
        else if (!par_ok) exp_parity++;
        else begin
            pend_q.push_back(b);
            if (pend_q.size() == N_BYTES) model_push(model_pack(1'b0));
        end
    endfunction

    function automatic void model_idle_flush();
        if (pend_q.size() > 0) model_push(model_pack(1'b1));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_flip);
        bit par_ok;
        par_ok  = !(HAS_PARITY && par_flip);
        uart_rx = 1'b0;
        tick(BP);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(BP);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = (^b) ^ PARITY_ODD[0] ^ par_flip;
        tick(BP);
`endif
        model_byte(b, stop_ok, par_ok);
        uart_rx = stop_ok;
        tick(BP);
        uart_rx = 1'b1;
        if (!stop_ok) tick(2 * BP);
    endtask

    task automatic long_gap();
        model_idle_flush();
        tick(20 * BP);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick(1);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        check({tag, "_tvalid"}, m_axis.M_AXIS_TVALID, 0);
        check({tag, "_tdata"}, m_axis.M_AXIS_TDATA, 0);
        check({tag, "_tkeep"}, m_axis.M_AXIS_TKEEP, 0);
        check({tag, "_tlast"}, m_axis.M_AXIS_TLAST, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_parity_err"}, parity_err, 0);
        check({tag, "_overflow"}, overflow, 0);
        tick(1);
    endtask

    // ---------------- consumer and monitor ----------------
    initial begin
        m_axis.M_AXIS_TREADY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_axis.M_AXIS_TREADY = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        cur_word = {m_axis.M_AXIS_TLAST, m_axis.M_AXIS_TKEEP, m_axis.M_AXIS_TDATA};
        if (reset) prev_stall = 1'b0;
        else begin
            if (frame_err) got_frame++;
            if (parity_err) got_parity++;
            if (overflow) got_ovf++;
            if (prev_stall) begin
                check("stall_tvalid", m_axis.M_AXIS_TVALID, 1);
                check("stall_hold", cur_word, prev_word);
            end
            if (m_axis.M_AXIS_TVALID && m_axis.M_AXIS_TREADY) begin
                if (exp_q.size() == 0) check("unexpected_word", cur_word, 0);
                else begin
                    want_word = exp_q.pop_front();
                    check("word", cur_word, want_word);
                end
            end
            prev_stall = m_axis.M_AXIS_TVALID && !m_axis.M_AXIS_TREADY;
            prev_word  = cur_word;
        end
    end

    initial begin
        #900000;
        check("watchdog", 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        bit s, f;
        tick(3);
        check_outputs_zero("reset");
        reset = 1'b0;
        tick(20);

        // One full word.
        send_byte(8'h11, 1, 0); send_byte(8'h22, 1, 0);
        send_byte(8'h33, 1, 0); send_byte(8'h44, 1, 0);
        long_gap();
        wait_drain();

        // Partial word flushed by idle timeout.
        send_byte(8'hA5, 1, 0); send_byte(8'h5A, 1, 0);
        long_gap();
        wait_drain();

        // Framing error, then a normal word.
        send_byte(8'h3C, 0, 0);
        tick(2 * BP);
        check("frame_err_count", got_frame, exp_frame);
        send_byte(8'hC1, 1, 0); send_byte(8'hC2, 1, 0);
        send_byte(8'hC3, 1, 0); send_byte(8'hC4, 1, 0);
        long_gap();
        wait_drain();

`ifdef UART_RX_PARITY_EN
        send_byte(8'h07, 1, 1);
        tick(2 * BP);
        check("parity_err_count", got_parity, exp_parity);
        send_byte(8'h07, 1, 0);
        long_gap();
        wait_drain();
`endif

        // One-cycle glitch in IDLE.
        uart_rx = 1'b0;
        tick(1);
        uart_rx = 1'b1;
        tick(3 * BP);
        check("glitch_frame_err", got_frame, exp_frame);
        check("glitch_parity_err", got_parity, exp_parity);
        check("glitch_no_word", exp_q.size(), 0);

        // Reset in the middle of a data bit drops the partial word.
        send_byte(8'h91, 1, 0); send_byte(8'h92, 1, 0);
        uart_rx = 1'b0;
        tick(3 * BP);
        reset   = 1'b1;
        uart_rx = 1'b1;
        pend_q.delete();
        tick(2);
        check_outputs_zero("mid_reset");
        reset = 1'b0;
        tick(2 * BP);
        send_byte(8'hD1, 1, 0); send_byte(8'hD2, 1, 0);
        send_byte(8'hD3, 1, 0); send_byte(8'hD4, 1, 0);
        long_gap();
        wait_drain();

        // Overflow with the consumer held off.
        hold_ready = 1'b1;
        tick(2);
        for (int i = 0; i < 3 * N_BYTES; i++) send_byte(8'($urandom_range(0, 255)), 1, 0);
        tick(2 * BP);
        check("overflow_count", got_ovf, exp_ovf);
        check("overflow_held_words", exp_q.size(), QUEUE_DEPTH);
        hold_ready = 1'b0;
        wait_drain();

        // Random bytes, errors and gaps.
        for (int i = 0; i < 60; i++) begin
            b = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 7) != 0);
            f = HAS_PARITY && ($urandom_range(0, 7) == 0);
            send_byte(b, s, f);
            if ($urandom_range(0, 4) == 0) long_gap();
            else tick($urandom_range(0, 4 * BP));
        end
        long_gap();
        wait_drain();
        check("final_frame_err", got_frame, exp_frame);
        check("final_parity_err", got_parity, exp_parity);
        check("final_overflow", got_ovf, exp_ovf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_uart_rx_packer.md
# axis_uart_rx_packer

Parametrised UART receiver that packs received bytes into AXI-Stream words of N_BYTES, with optional parity checking, framing-error detection, and idle-timeout flushing of partial words (TKEEP/TLAST). Sits between an external UART_RX pin and any AXIS consumer. Successor to the fixed-format UART RX bridge: adds partial-word handling, error reporting and an internal first-word-fall-through queue with overflow detection.

## Interface
- FREQ_HZ, 100000000, clk frequency in Hz
- UART_SPEED, 115200, baud rate
- N_BYTES, 4, bytes per output word (1..64)
- QUEUE_DEPTH, 16, output queue depth in words (power of two, ≥2)
- IDLE_TIMEOUT_BITS, 16, idle bit periods after a stop bit before a partial word is flushed (≥1)
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only with UART_RX_PARITY_EN)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- UART_RX  in  1  asynchronous serial input, idle high
- M_AXIS_TDATA  out  N_BYTES*8  packed bytes; first received byte in [7:0]
- M_AXIS_TKEEP  out  N_BYTES  valid-byte mask, contiguous from bit 0
- M_AXIS_TLAST  out  1  high on words flushed by idle timeout
- M_AXIS_TVALID  out  1  queue not empty
- M_AXIS_TREADY  in  1  consumer ready
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low
- PARITY_ERR  out  1  one-cycle pulse: parity mismatch (tied 0 without the macro)
- OVERFLOW  out  1  one-cycle pulse: word dropped because the queue was full

## Operation
- UART_RX passes through a 2-FF synchroniser; all decisions use the synchronised value rx_s.
- BIT_PERIOD = FREQ_HZ/UART_SPEED (integer division), HALF = BIT_PERIOD/2. A single down-counter is reloaded per state.
- FSM states:
  - IDLE: a falling edge on rx_s loads HALF and moves to START.
  - START: at terminal count, rx_s low → DATA (reload BIT_PERIOD); rx_s high is a glitch → IDLE, with no error.
  - DATA: sample 8 bits LSB-first, one per BIT_PERIOD. After bit 7 → PARITY if the macro is defined, otherwise → STOP.
  - PARITY: sample one bit.
  - STOP: sample the stop bit. High → byte accepted, → IDLE. Low → byte discarded, FRAME_ERR pulse, → BREAK.
  - BREAK: wait for rx_s high, then → IDLE.
- A parity mismatch discards the byte and pulses PARITY_ERR, even if the stop bit is good. If both parity and stop bit are bad, only FRAME_ERR pulses.
- Packing: an accepted byte is written to lane byte_cnt and byte_cnt increments. When byte_cnt reaches N_BYTES, the word is pushed with TKEEP all ones and TLAST=0, and byte_cnt returns to 0.
- Idle flush: the idle counter counts while in IDLE with byte_cnt>0 and clears on any start edge. After IDLE_TIMEOUT_BITS*BIT_PERIOD cycles, the partial word is pushed with TKEEP=(1<<byte_cnt)-1, TLAST=1, and unused lanes zeroed; byte_cnt returns to 0.
- Queue: first-word-fall-through, DEPTH words of {TDATA,TKEEP,TLAST}. A push when full drops the word and pulses OVERFLOW. A push and a pop in the same cycle when full are both accepted.
- AXIS: a transfer occurs when TVALID&TREADY. Outputs hold stable while TVALID&!TREADY.

## Timing
- Reset: TVALID, TDATA, TKEEP, TLAST, FRAME_ERR, PARITY_ERR and OVERFLOW are all 0. FSM → IDLE, byte_cnt=0, queue empty, idle counter cleared.
- Reset mid-frame aborts the frame and drops the partial word. Reset takes priority over every other event.
- Sample points: the start bit is checked HALF+2 cycles after the pin's falling edge (2 cycles of synchroniser delay). Data bit k is sampled at HALF+(k+1)*BIT_PERIOD after start detection.
- Push occurs 1 cycle after the final stop-bit sample. TVALID rises the cycle after the push when the queue was empty.
- Error pulses occur 1 cycle after the offending sample.
- A full word and the idle timeout cannot coincide, because byte_cnt resets to 0 on a full push.

## Configuration
- UART_RX_PARITY_EN defined: the frame is start + 8 data + 1 parity (even or odd per PARITY_ODD) + 1 stop, and PARITY_ERR is live.
- Not defined: the frame is 8N1, the PARITY state is removed, and PARITY_ERR is constant 0.

## Test plan
- N_BYTES=4, 8N1, send 0x11,0x22,0x33,0x44 with TREADY=1 → one word TDATA=0x44332211, TKEEP=0xF, TLAST=0.
- N_BYTES=4, send 0xA5,0x5A then idle 16 bit periods → TDATA=0x00005AA5, TKEEP=0x3, TLAST=1, exactly one word.
- Send 0x3C with the stop bit driven low → FRAME_ERR pulses once, no word; line then high and 4 good bytes → normal word.
- UART_RX_PARITY_EN, even parity, 0x07 with parity bit 0 → PARITY_ERR pulse, byte dropped; same byte with parity 1 → accepted.
- QUEUE_DEPTH=2, TREADY=0, send 3 full words → 2 words held, OVERFLOW pulses once; with TREADY=1, words 1 and 2 are read in order.
- 1-cycle low glitch on UART_RX in IDLE → no frame, no error; reset asserted during DATA → all outputs 0, next frame received correctly.
